// File: rtl/anim_timer_bank.sv
// anim_timer_bank: CHANNELS independent one-shot/auto-reload down-counters sharing one tick.
// Build option ANIM_TIMER_PRESCALE_EN: when defined, the tick is divided by presc_div_in+1.
module anim_timer_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 32,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       load_in,
  input  logic [CHANNELS*CNT_W-1:0] load_data_in,
  input  logic [CHANNELS-1:0]       auto_reload_in,
  input  logic [PRESC_W-1:0]        presc_div_in,
  input  logic                      pause_in,
  output logic [CHANNELS-1:0]       active_out,
  output logic [CHANNELS-1:0]       expire_out,
  output logic [CHANNELS*CNT_W-1:0] count_out
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic w_tick;

`ifdef ANIM_TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc_cnt;

  // >= rather than == so a divider lowered mid-count ticks on the next unpaused cycle
  assign w_tick = (r_presc_cnt >= presc_div_in) & ~pause_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else if (!pause_in) begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end
`else
  logic w_unused_presc_div;

  assign w_unused_presc_div = ^presc_div_in;
  assign w_tick             = ~pause_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_reload;
      logic             r_mode;
      logic             r_expire;
      logic [CNT_W-1:0] w_data;

      assign w_data = load_data_in[gi*CNT_W +: CNT_W];

      // Load beats expiry; a counter parked at zero simply holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_reload <= '0;
          r_mode   <= 1'b0;
          r_expire <= 1'b0;
        end else begin
          r_expire <= 1'b0;
          if (load_in[gi]) begin
            r_cnt    <= w_data;
            r_reload <= w_data;
            r_mode   <= auto_reload_in[gi];
          end else if (w_tick && (r_cnt == C_ONE)) begin
            r_cnt    <= (r_mode && (r_reload != '0)) ? r_reload : '0;
            r_expire <= 1'b1;
          end else if (w_tick && (r_cnt > C_ONE)) begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
      end

      assign count_out[gi*CNT_W +: CNT_W] = r_cnt;
      assign active_out[gi]               = |r_cnt;
      assign expire_out[gi]               = r_expire;
    end
  endgenerate

endmodule

// File: doc/anim_timer_bank.md
# anim_timer_bank

Multi-channel, parametrised successor to the single animation frame counter. It provides `CHANNELS` independent down-counters of `CNT_W` bits, all advanced by one shared prescaled tick. Each channel can run one-shot or auto-reload and emits an expiry pulse. It sits beside the dcache, loaded from the memory-mapped frame-counter registers. Its `active_out` bits feed the ALU source mux (x15-style sync bits) and the seven-segment animation logic.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent counter channels (>=1)
- `CNT_W`, 32, counter and reload width in bits (>=2)
- `PRESC_W`, 8, prescaler divider width in bits (>=1)

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_in`  in  CHANNELS  per-channel load strobe.
- `load_data_in`  in  CHANNELS*CNT_W  per-channel load value; channel i uses bits [i*CNT_W +: CNT_W].
- `auto_reload_in`  in  CHANNELS  per-channel mode, sampled on load: 1 = auto-reload, 0 = one-shot.
- `presc_div_in`  in  PRESC_W  divider; a tick occurs every `presc_div_in`+1 cycles.
- `pause_in`  in  1  freezes the prescaler and all counters.
- `active_out`  out  CHANNELS  bit i is the OR-reduction of counter i.
- `expire_out`  out  CHANNELS  one-cycle pulse when counter i expires.
- `count_out`  out  CHANNELS*CNT_W  live counter values, packed like `load_data_in`.

## Operation
- **Prescaler**
  - `presc_cnt` is `PRESC_W` bits wide.
  - `tick` = (`presc_cnt` >= `presc_div_in`) & ~`pause_in`.
  - On tick, `presc_cnt` <= 0. Otherwise, if ~`pause_in`, `presc_cnt` <= `presc_cnt`+1.
  - Comparison is >=, so lowering `presc_div_in` mid-count yields a tick on the next unpaused cycle.
  - The prescaler is shared by all channels. Loads do not reset it.
- **Per-channel registers**: `cnt[i]`, `reload[i]`, `mode[i]`.
- **Per-channel update priority**, highest first:
  1. `load_in[i]`: `cnt` <= data, `reload` <= data, `mode` <= `auto_reload_in[i]`. No expiry. Applies even when paused and on tick cycles.
  2. tick & `cnt`==1:
     - If `mode` & `reload`!=0: `cnt` <= `reload`.
     - Else: `cnt` <= 0.
     - Either way, expiry is flagged.
  3. tick & `cnt`>1: `cnt` <= `cnt`-1.
  4. Otherwise `cnt` holds. A counter at 0 never wraps or underflows.
- **Loading 0**: the channel goes inactive immediately with no expiry, regardless of mode.
- **Outputs**
  - `expire_out[i]` is a register set to 1 for exactly one cycle on the edge where case 2 occurred; otherwise it is set to 0.
  - `active_out` and `count_out` are combinational from the counter registers.
- **Independence**: channels never interact except through the shared tick. Simultaneous loads and expiries on different channels are all honoured in the same cycle.

## Timing
- **Reset values**: while `rst`=1, asynchronously: all `cnt`, `reload`, `mode`, `presc_cnt` = 0; `active_out`=0, `expire_out`=0, `count_out`=0.
- **Reset mid-count**: all state is lost. After release, counting requires a new load.
- **Load latency**: `load_in` sampled at edge k makes `count_out`=data and `active_out`=(data!=0) visible after edge k.
- **First tick after load**: occurs on the next prescaler wrap, so the first decrement after a load comes 1 to `presc_div_in`+1 cycles later.
- **Expiry from N** with `presc_div_in`=D and no pause:
  - `cnt` reaches 0 (or reloads) N ticks after the load.
  - `expire_out` is high during the cycle following that edge.
- **Auto-reload period**: exactly `reload`*(D+1) cycles between expiry pulses.
- **Pause**: while `pause_in`=1, no state changes other than loads.

## Configuration
- Macro: `ANIM_TIMER_PRESCALE_EN`.
- **Defined**: prescaler as described.
- **Undefined**:
  - `tick` = ~`pause_in` every cycle.
  - `presc_div_in` is ignored; the port remains for interface stability.
  - No prescaler register is synthesised.

## Test plan
- **Reset**: assert `rst` asynchronously mid-count with ch0=5 -> all outputs 0 immediately; after release, ch0 stays 0 with no `expire_out`.
- **One-shot**: CHANNELS=2, D=0, load ch0=3 mode 0 -> `count_out` 3,2,1,0 on consecutive cycles; one `expire_out[0]` pulse; `active_out[0]` low after 0; no further pulses.
- **Auto-reload**: D=3, load ch1=2 mode 1 -> `expire_out[1]` pulses every 8 cycles for 5 periods; `active_out[1]` never drops.
- **Priority**: load ch0=7 on the same edge where ch0 would go 1->0 -> `count_out`=7 and no expire pulse. Separately, load 0 in auto-reload mode -> inactive with no pulse.
- **Pause**: pause for 10 cycles mid-count with D=2 -> count and prescaler frozen; a load during the pause still applies; on resume the remaining count continues unchanged.
- **Macro off**: `ANIM_TIMER_PRESCALE_EN` undefined, D=200, load 4 -> expires 4 cycles after the load edge, i.e. D is ignored.
